// File: rtl/pc_sequencer_if.sv
// Fetch-path bundle: redirect inputs, instruction-memory handshake and decode-side instruction outputs.
// Ports: master = sequencer side (drives imem_req/imem_addr/inst_*/pc); slave = core/memory environment side.
// The sequencer has no backpressure of its own; the environment stalls it via stall and imem_ack.
interface pc_sequencer_if;
    // redirect and decode control
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    // instruction memory handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // instruction delivered to decode
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, exc,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, exc,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer: one outstanding imem request, redirect handling.
// Latency: imem_ack at edge N gives inst_valid at N+1; one instruction per 2 cycles at best.
// Backpressure: stall holds the delivered instruction; imem address held stable until imem_ack.
// Ports: clk, rst (async active-high), io (pc_sequencer_if.master) carrying all fetch/decode signals.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0180,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.master     io
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        redir;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;
    logic        imem_req;

    // exc > jump > branch; targets are always word aligned
    assign redir     = io.exc | io.jump | io.branch_taken;
    assign redir_raw = io.exc  ? EXC_VEC :
                       io.jump ? io.jump_target : io.branch_target;
    assign redir_tgt = redir_raw & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        imem_req     = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (!io.imem_ack) begin
                    // Request in flight: the address must not move, so park the redirect.
                    if (redir) begin
                        redir_pend_d = 1'b1;
                        redir_pc_d   = redir_tgt;
                    end
                end else if (redir) begin
                    // Returning word is stale; a same-cycle redirect beats any parked one.
                    pc_d         = redir_tgt;
                    redir_pend_d = 1'b0;
                end else if (redir_pend_q) begin
                    pc_d         = redir_pc_q;
                    redir_pend_d = 1'b0;
                end else begin
                    inst_d       = io.imem_rdata;
                    inst_pc_d    = pc_q;
                    pc_d         = pc_q + PC_STEP;
                    inst_valid_d = 1'b1;
                    state_d      = DELIVER;
                end
            end
            DELIVER: begin
                if (redir) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redir_tgt;
                    state_d      = FETCH;
                end else if (!io.stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign io.imem_req   = imem_req;
    assign io.imem_addr  = pc_q;
    assign io.pc         = pc_q;
    assign io.inst_valid = inst_valid_q;
    assign io.inst       = inst_q;
    assign io.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch sequencing, stall hold, redirects, wrap and reset abort.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each comparison is an immediate assertion; failures are counted and reported.
module tb_pc_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .EXC_VEC  (32'h0000_0180),
        .PC_STEP  (32'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus.jump           = 1'b0;
        bus.jump_target    = '0;
        bus.exc            = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        tick();
        tick();

        // reset state
        chk("rst_pc",    bus.pc,         32'h0);
        chk("rst_req",   {31'b0, bus.imem_req},   32'h0);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("rst_inst",  bus.inst,       32'h0);
        chk("rst_ipc",   bus.inst_pc,    32'h0);

        // 1: sequential fetch, ack one cycle after request
        rst = 1'b0;
        chk("boot_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("f0_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("f0_addr_a", bus.imem_addr, 32'h0);
        tick();
        chk("f0_addr_b", bus.imem_addr, 32'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("d0_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk("d0_inst",  bus.inst,    32'hA000_0000);
        chk("d0_ipc",   bus.inst_pc, 32'h0);
        chk("d0_pc",    bus.pc,      32'h4);
        chk("d0_req",   {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("f1_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("f1_addr",  bus.imem_addr, 32'h4);
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0004;
        tick();
        bus.imem_ack = 1'b0;
        chk("d1_ipc", bus.inst_pc, 32'h4);

        // 2: stall held three cycles in DELIVER
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, bus.inst_valid}, 32'h1);
            chk("stall_inst",  bus.inst,    32'hA000_0004);
            chk("stall_ipc",   bus.inst_pc, 32'h4);
            chk("stall_req",   {31'b0, bus.imem_req}, 32'h0);
        end
        bus.stall = 1'b0;
        tick();
        chk("f2_addr", bus.imem_addr, 32'h8);
        chk("f2_req",  {31'b0, bus.imem_req}, 32'h1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0008;
        tick();
        bus.imem_ack = 1'b0;
        chk("d2_ipc",  bus.inst_pc, 32'h8);
        chk("d2_inst", bus.inst,    32'hA000_0008);

        // 3: jump in DELIVER (with stall) redirects, target aligned
        bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0103;
        tick();
        bus.stall = 1'b0; bus.jump = 1'b0;
        chk("jmp_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("jmp_addr",  bus.imem_addr, 32'h0000_0100);
        chk("jmp_req",   {31'b0, bus.imem_req}, 32'h1);

        // 4: branch while fetch in flight, ack two cycles later
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0040;
        tick();
        bus.branch_taken = 1'b0;
        chk("br_hold_addr", bus.imem_addr, 32'h0000_0100);
        tick();
        chk("br_hold_addr2", bus.imem_addr, 32'h0000_0100);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("br_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("br_addr",  bus.imem_addr, 32'h0000_0040);
        chk("br_req",   {31'b0, bus.imem_req}, 32'h1);

        // 5: exc beats jump on an acked cycle; then wrap at top of address space
        bus.exc = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0200;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0000;
        tick();
        bus.exc = 1'b0; bus.jump = 1'b0;
        chk("exc_pc",    bus.pc, 32'h0000_0180);
        chk("exc_valid", {31'b0, bus.inst_valid}, 32'h0);
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFF;
        tick();
        bus.jump = 1'b0;
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        bus.imem_rdata = 32'hA0FF_FFFC;
        tick();
        bus.imem_ack = 1'b0;
        chk("wrap_pc",  bus.pc,      32'h0);
        chk("wrap_ipc", bus.inst_pc, 32'hFFFF_FFFC);
        // ack outside FETCH has no effect
        bus.stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;
        tick();
        chk("dlv_ack_inst", bus.inst, 32'hA0FF_FFFC);
        chk("dlv_ack_pc",   bus.pc,   32'h0);
        bus.stall = 1'b0; bus.imem_ack = 1'b0;
        tick();
        chk("post_wrap_addr", bus.imem_addr, 32'h0);

        // 6: reset mid-FETCH with a parked redirect, ack after release ignored
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0080;
        tick();
        bus.branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_pc",  bus.pc, 32'h0);
        chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        rst = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_2222;
        tick();
        chk("rel_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("rel_pc",    bus.pc, 32'h0);
        chk("rel_req",   {31'b0, bus.imem_req}, 32'h1);
        bus.imem_rdata = 32'h3333_3333;
        tick();
        bus.imem_ack = 1'b0;
        chk("rel_inst", bus.inst,    32'h3333_3333);
        chk("rel_ipc",  bus.inst_pc, 32'h0);
        chk("rel_pc2",  bus.pc,      32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
